fiber_dram_responder: RTL and testbench

- DRAM-side responder for the fiber cache's DRAM crossbar. It answers the cache's line-fetch reads and accepts its writebacks.
- It holds a small backing memory and returns read data after a fixed, parameterised latency.
- Up to QUEUE_DEPTH outstanding reads are buffered. Data is returned in order over a valid/ready channel that drives the cache's inbox port.
- Used as the synthesizable DRAM stand-in for system benches and FPGA bring-up.

---
 rtl/fiber_dram_if.sv | 53 +++++
 rtl/fiber_dram_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_fiber_dram_responder.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fiber_dram_if.sv
// fiber_dram_if: request/response bundle between the fiber cache's DRAM
// crossbar (master) and a DRAM-side responder (slave).
//
// Handshake semantics for both channels: a beat transfers on a rising clock
// edge where valid and ready are both 1. Once valid is raised, the source
// holds valid and its payload stable until that edge. Ready may be raised or
// lowered freely and never depends combinationally on valid.
//
// Signals (named from the responder's point of view):
//   i_req_valid / o_req_ready   request channel, cache -> responder
//   i_req_write                 1 = writeback, 0 = line-fetch read
//   i_addr                      request address
//   i_wdata                     writeback data
//   o_rdata / o_rdata_valid /
//   i_rdata_ready               read response channel, responder -> cache
//   o_err                       out-of-range pulse, present only when
//                               FIBER_DRAM_OOR_CHECK_EN is defined
interface fiber_dram_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 64
);
    logic                  i_req_valid;
    logic                  o_req_ready;
    logic                  i_req_write;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_wdata;
    logic [DATA_WIDTH-1:0] o_rdata;
    logic                  o_rdata_valid;
    logic                  i_rdata_ready;
`ifdef FIBER_DRAM_OOR_CHECK_EN
    logic                  o_err;

    modport master (
        output i_req_valid, i_req_write, i_addr, i_wdata, i_rdata_ready,
        input  o_req_ready, o_rdata, o_rdata_valid, o_err
    );

    modport slave (
        input  i_req_valid, i_req_write, i_addr, i_wdata, i_rdata_ready,
        output o_req_ready, o_rdata, o_rdata_valid, o_err
    );
`else
    modport master (
        output i_req_valid, i_req_write, i_addr, i_wdata, i_rdata_ready,
        input  o_req_ready, o_rdata, o_rdata_valid
    );

    modport slave (
        input  i_req_valid, i_req_write, i_addr, i_wdata, i_rdata_ready,
        output o_req_ready, o_rdata, o_rdata_valid
    );
`endif
endinterface

// File: rtl/fiber_dram_responder.sv
// fiber_dram_responder: synthesizable DRAM stand-in for the fiber cache.
// Writebacks land in a small backing memory with no response beat. Reads are
// queued in a QUEUE_DEPTH-entry index FIFO and answered in order, each one
// LATENCY wait cycles after it leaves the FIFO, over a valid/ready channel.
//
// Ports:
//   i_clk        rising-edge clock
//   i_nreset     synchronous active-low reset (memory contents survive)
//   bus          fiber_dram_if slave modport (request + response channels)
//   o_dbg_state  current FSM state (0 = IDLE, 1 = WAIT, 2 = RESP)
//
// Optional feature macro: FIBER_DRAM_OOR_CHECK_EN. When defined, any request
// with nonzero address bits above MEM_DEPTH_LOG2 pulses bus.o_err for one
// cycle; such writes are dropped and such reads return all-ones. When not
// defined, the upper address bits simply alias onto the memory.
module fiber_dram_responder #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 64,
    parameter int MEM_DEPTH_LOG2 = 8,
    parameter int LATENCY        = 4,
    parameter int QUEUE_DEPTH    = 4
) (
    input  logic               i_clk,
    input  logic               i_nreset,
    fiber_dram_if.slave        bus,
    output logic [1:0]         o_dbg_state
);
    localparam int MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam int PTR_W     = $clog2(QUEUE_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int LAT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_DEPTH);
    localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Request decode
    logic [MEM_DEPTH_LOG2-1:0] req_idx;
    logic                      req_ready;
    logic                      req_accept;
    logic                      req_oor;
    logic                      push;
    logic                      pop;
    logic                      mem_we;

    // Storage (no reset: memory contents persist across reset)
    logic [DATA_WIDTH-1:0]     mem_q      [MEM_DEPTH];
    logic [MEM_DEPTH_LOG2-1:0] fifo_idx_q [QUEUE_DEPTH];

    // FIFO bookkeeping
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      fifo_empty;

    // FSM and response registers
    state_e                    state_q, state_d;
    logic [LAT_W-1:0]          cnt_q, cnt_d;
    logic [MEM_DEPTH_LOG2-1:0] cur_idx_q, cur_idx_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic                      rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]     mem_rd;
    logic [DATA_WIDTH-1:0]     sample_data;

`ifdef FIBER_DRAM_OOR_CHECK_EN
    logic                      fifo_oor_q [QUEUE_DEPTH];
    logic                      cur_oor_q, cur_oor_d;
    logic                      err_q, err_d;
`else
    logic                      unused_addr_hi;
`endif

    assign req_idx    = bus.i_addr[MEM_DEPTH_LOG2-1:0];
    // Ready comes only from the registered count, so a pop in this cycle
    // never opens a slot for a request in the same cycle.
    assign req_ready  = (count_q != FULL_COUNT);
    assign req_accept = bus.i_req_valid & req_ready & i_nreset;
    assign fifo_empty = (count_q == '0);

`ifdef FIBER_DRAM_OOR_CHECK_EN
    assign req_oor = |bus.i_addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2];
`else
    assign req_oor        = 1'b0;
    assign unused_addr_hi = ^bus.i_addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2];
`endif

    assign push   = req_accept & ~bus.i_req_write;
    assign mem_we = req_accept &  bus.i_req_write & ~req_oor;

    // Read data is captured on the WAIT->RESP edge; a write accepted on that
    // same edge must win, so forward it around the memory.
    always_comb begin
        mem_rd = mem_q[cur_idx_q];
        if (mem_we && (req_idx == cur_idx_q)) begin
            mem_rd = bus.i_wdata;
        end
    end

`ifdef FIBER_DRAM_OOR_CHECK_EN
    assign sample_data = cur_oor_q ? {DATA_WIDTH{1'b1}} : mem_rd;
`else
    assign sample_data = mem_rd;
`endif

    // Next-state and response logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_idx_d = cur_idx_q;
        rdata_d   = rdata_q;
        rvalid_d  = rvalid_q;
        pop       = 1'b0;
`ifdef FIBER_DRAM_OOR_CHECK_EN
        cur_oor_d = cur_oor_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    cur_idx_d = fifo_idx_q[rd_ptr_q];
`ifdef FIBER_DRAM_OOR_CHECK_EN
                    cur_oor_d = fifo_oor_q[rd_ptr_q];
`endif
                    cnt_d     = LAT_RELOAD;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d  = sample_data;
                    rvalid_d = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.i_rdata_ready) begin
                    rvalid_d = 1'b0;
                    if (!fifo_empty) begin
                        // Back-to-back: next read starts its wait right away.
                        pop       = 1'b1;
                        cur_idx_d = fifo_idx_q[rd_ptr_q];
`ifdef FIBER_DRAM_OOR_CHECK_EN
                        cur_oor_d = fifo_oor_q[rd_ptr_q];
`endif
                        cnt_d     = LAT_RELOAD;
                        state_d   = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO pointers wrap naturally since QUEUE_DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

`ifdef FIBER_DRAM_OOR_CHECK_EN
    assign err_d = req_accept & req_oor;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_nreset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cur_idx_q <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
`ifdef FIBER_DRAM_OOR_CHECK_EN
            cur_oor_q <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_idx_q <= cur_idx_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
`ifdef FIBER_DRAM_OOR_CHECK_EN
            cur_oor_q <= cur_oor_d;
            err_q     <= err_d;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem_q[req_idx] <= bus.i_wdata;
        end
        if (push) begin
            fifo_idx_q[wr_ptr_q] <= req_idx;
`ifdef FIBER_DRAM_OOR_CHECK_EN
            fifo_oor_q[wr_ptr_q] <= req_oor;
`endif
        end
    end

    assign bus.o_req_ready   = req_ready;
    assign bus.o_rdata       = rdata_q;
    assign bus.o_rdata_valid = rvalid_q;
`ifdef FIBER_DRAM_OOR_CHECK_EN
    assign bus.o_err         = err_q;
`endif
    assign o_dbg_state       = state_q;

endmodule

// File: tb/tb_fiber_dram_responder.sv
// tb_fiber_dram_responder: randomized and directed bench for
// fiber_dram_responder. A transaction-level model tracks accepted reads in
// order, the backing memory and response timing, and every cycle compares
// ready/valid/data (and o_err when FIBER_DRAM_OOR_CHECK_EN is defined).
module tb_fiber_dram_responder;
  localparam int DW  = 16;
  localparam int AW  = 64;
  localparam int ML  = 8;
  localparam int LAT = 4;
  localparam int QD  = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic [1:0] dbg_state;
  int         edge_n = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  fiber_dram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

  fiber_dram_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH_LOG2(ML),
    .LATENCY(LAT), .QUEUE_DEPTH(QD)
  ) dut (
    .i_clk(clk),
    .i_nreset(nreset),
    .bus(bus_if),
    .o_dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int idx;
    int acc;   // edge at which the read was accepted
    bit oor;
  } rd_t;

  logic [DW-1:0] model_mem [256];
  rd_t           rd_q[$];     // accepted reads not yet handed over
  logic [DW-1:0] exp_q[$];    // captured response data, in order
  int            last_hs = 0; // edge of last response handshake or reset
  bit            model_live = 0;
  bit            rdata_zero = 0;
  bit            err_exp = 0;

  // A read leaves the queue at max(accept+1, previous handshake) and its data
  // is sampled and shown LAT edges later. Checks run on the falling edge,
  // then the inputs now stable are applied to the model for the next edge.
  always @(negedge clk) begin
    int  e, start, v, cnt;
    bit  exp_valid, head_popped, oor, mready;
    e = edge_n;
    exp_valid = 0;
    head_popped = 0;
    if (rd_q.size() > 0) begin
      start = (rd_q[0].acc + 1 > last_hs) ? rd_q[0].acc + 1 : last_hs;
      v = start + LAT;
      head_popped = (e >= start);
      exp_valid = (e >= v);
      if (e == v) begin
        exp_q.push_back(rd_q[0].oor ? {DW{1'b1}} : model_mem[rd_q[0].idx]);
        rdata_zero = 0;
      end
    end
    cnt = rd_q.size() - (head_popped ? 1 : 0);
    mready = (cnt != QD);

    if (model_live) begin
      check_val("req_ready", bus_if.o_req_ready, mready);
      check_val("rdata_valid", bus_if.o_rdata_valid, exp_valid);
      if (exp_valid && exp_q.size() > 0)
        check_val("rdata", bus_if.o_rdata, exp_q[0]);
      else if (rdata_zero)
        check_val("rdata_after_reset", bus_if.o_rdata, 0);
      if (rd_q.size() == 0)
        check_val("fsm_idle", dbg_state, 0);
`ifdef FIBER_DRAM_OOR_CHECK_EN
      check_val("err", bus_if.o_err, err_exp);
`endif
    end

    err_exp = 0;
    if (!nreset) begin
      rd_q.delete();
      exp_q.delete();
      last_hs = e + 1;
      model_live = 1;
      rdata_zero = 1;
    end else if (model_live) begin
      if (exp_valid && bus_if.i_rdata_ready === 1'b1) begin
        last_hs = e + 1;
        void'(rd_q.pop_front());
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (bus_if.i_req_valid && mready) begin
`ifdef FIBER_DRAM_OOR_CHECK_EN
        oor = (bus_if.i_addr[AW-1:ML] != '0);
`else
        oor = 0;
`endif
        err_exp = oor;
        if (bus_if.i_req_write) begin
          if (!oor) model_mem[int'(bus_if.i_addr[ML-1:0])] = bus_if.i_wdata;
        end else begin
          rd_q.push_back('{idx: int'(bus_if.i_addr[ML-1:0]), acc: e + 1, oor: oor});
        end
      end
    end
  end

  // ---------------- response-ready driver ----------------
  int rdy_mode = 1; // 0 random, 1 always ready, 2 held low

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus_if.i_rdata_ready = 1'($urandom_range(0, 1));
      1:       bus_if.i_rdata_ready = 1'b1;
      default: bus_if.i_rdata_ready = 1'b0;
    endcase
  end

  // ---------------- request driver tasks ----------------
  task automatic send(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int guard = 0;
    bit done = 0;
    bus_if.i_req_valid = 1'b1;
    bus_if.i_req_write = wr;
    bus_if.i_addr      = addr;
    bus_if.i_wdata     = data;
    while (!done) begin
      @(negedge clk);
      if (bus_if.o_req_ready) done = 1;
      else if (++guard > 500) begin
        check_val("req_accept_timeout", 0, 1);
        done = 1;
      end
    end
    @(posedge clk); #1;
    bus_if.i_req_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g = 0;
    while (rd_q.size() != 0 && g < 600) begin
      @(negedge clk);
      g++;
    end
    check_val("drain_timeout", rd_q.size() == 0, 1);
    idle_cycles(2);
  endtask

  task automatic wait_valid();
    int g = 0;
    while (!bus_if.o_rdata_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    check_val("valid_timeout", bus_if.o_rdata_valid, 1);
    @(posedge clk); #1;
  endtask

  function automatic logic [AW-1:0] rand_addr(input int idx);
    logic [AW-1:0] a;
    a = {$urandom, $urandom};
`ifdef FIBER_DRAM_OOR_CHECK_EN
    if ($urandom_range(0, 7) != 0) a[AW-1:ML] = '0;
`endif
    a[ML-1:0] = ML'(idx);
    return a;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] hi_addr;
    bus_if.i_req_valid = 1'b0;
    bus_if.i_req_write = 1'b0;
    bus_if.i_addr      = '0;
    bus_if.i_wdata     = '0;
    nreset = 1'b0;
    idle_cycles(3);
    nreset = 1'b1;
    idle_cycles(2);

    // Known contents everywhere so any read has a defined expectation.
    for (int i = 0; i < 256; i++) send(1, AW'(i), DW'($urandom));

    // Top index, aliased high bits in the default build.
`ifdef FIBER_DRAM_OOR_CHECK_EN
    hi_addr = 64'h0000_0000_0000_00FF;
`else
    hi_addr = 64'h0000_0000_FFFF_FFFF;
`endif
    send(1, hi_addr, 16'h1234);
    send(0, 64'hFF, 16'h0);
    drain();

    // Long backpressure on one response.
    send(1, 64'h10, 16'hBEEF);
    rdy_mode = 2;
    send(0, 64'h10, 16'h0);
    idle_cycles(14);
    rdy_mode = 1;
    drain();

    // Fill the read queue while the response is blocked.
    for (int i = 1; i <= 5; i++) send(1, AW'(i), DW'(i));
    rdy_mode = 2;
    for (int i = 1; i <= 5; i++) send(0, AW'(i), 16'h0);
    idle_cycles(20);
    rdy_mode = 1;
    drain();

    // Write right behind a read to the same index is visible.
    send(1, 64'h7, 16'hAAAA);
    send(0, 64'h7, 16'h0);
    send(1, 64'h7, 16'h5555);
    drain();
    // Write after the data was sampled is not.
    send(1, 64'h7, 16'hAAAA);
    rdy_mode = 2;
    send(0, 64'h7, 16'h0);
    wait_valid();
    send(1, 64'h7, 16'h5555);
    rdy_mode = 1;
    drain();

    // Reset while a read is waiting and two more are queued.
    rdy_mode = 2;
    send(0, 64'h20, 16'h0);
    send(0, 64'h21, 16'h0);
    send(0, 64'h22, 16'h0);
    idle_cycles(1);
    nreset = 1'b0;
    idle_cycles(2);
    nreset = 1'b1;
    rdy_mode = 1;
    idle_cycles(3);
    send(0, 64'h20, 16'h0);
    drain();

`ifdef FIBER_DRAM_OOR_CHECK_EN
    send(1, 64'h0, 16'h0F0F);
    send(0, 64'h0000_0001_0000_0000, 16'h0);
    send(1, 64'h0000_0001_0000_0000, 16'h1111);
    send(0, 64'h0, 16'h0);
    drain();
`endif

    // Random mix of reads, writes, gaps and response backpressure.
    rdy_mode = 0;
    for (int n = 0; n < 400; n++) begin
      send(1'($urandom_range(0, 1)), rand_addr($urandom_range(0, 255)), DW'($urandom));
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 6));
    end
    rdy_mode = 1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
